sumu3_arb: RTL
==============

SUMU3_ARB -- requirements
Module: sumu3_arb

Interface
REQ-001 Parameter: SETTLE, 1, cycles operands are held on ar_a/ar_b before the result is captured; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester N offers an operation.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  2 each  operands.
REQ-007 req0_op, req1_op  input  2 each  operation select: 00 sum, 01 mult, 10 abb, 11 illegal.
REQ-008 ar_a, ar_b  output  2 each  operands driven to the shared sumu3 arithmetic unit.
REQ-009 ar_sum, ar_mult, ar_abb  input  3 each  results returned by the sumu3 unit.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_data  output  3  selected result.
REQ-013 rsp_id  output  1  index of the requester that owns the response.
REQ-014 rsp_err  output  1  high when the operation code was 11.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; all outputs come from registers except reqN_ready, which is decoded from registered state.
REQ-017 Grant in IDLE: only one valid requester -> that requester; both valid -> the requester other than last_grant; neither valid -> no grant.
REQ-018 reqN_ready is high only in IDLE for the granted requester; it is never high for both requesters; it is low in ISSUE, in RESP and during reset.
REQ-019 Handshake occurs when reqN_valid and reqN_ready are both high at a rising edge. On that edge: latch a, b, op; set rsp_id to N; set last_grant to N; go to ISSUE.
REQ-020 Operands are sampled only at the handshake edge; requester inputs have no effect at any other time. A requester may drop valid before it is granted; this has no side effects.
REQ-021 ar_a/ar_b are updated on the handshake edge from the latched operands and stay stable through ISSUE and RESP; they keep their last value while in IDLE.
REQ-022 ISSUE lasts exactly SETTLE cycles, timed by a down-counter. On the last ISSUE edge, the result is captured into rsp_data:
  - op 00 -> ar_sum
  - op 01 -> ar_mult
  - op 10 -> ar_abb
  - op 11 -> rsp_data 3'b000 and rsp_err 1; rsp_err is 0 for all other op codes.
  On that edge the FSM also sets rsp_valid and moves to RESP.
REQ-023 Latency: rsp_valid rises SETTLE+1 cycles after the handshake cycle (SETTLE=1: the handshake is in cycle 0 and rsp_valid is high in cycle 2).
REQ-024 In RESP, rsp_valid, rsp_data, rsp_id and rsp_err hold stable until rsp_ready is high at an edge. On that edge: clear rsp_valid and return to IDLE.
REQ-025 No request is accepted in the cycle that completes the response; the next accept is no earlier than the following IDLE cycle. Peak throughput is one operation per SETTLE+2 cycles.
REQ-026 rsp_ready asserted outside RESP is ignored.
REQ-027 Results are 3-bit, passed through from the sumu3 unit without modification or widening.

Reset
REQ-028 While rst is high at an edge:
  - state -> IDLE; busy 0
  - rsp_valid, rsp_data, rsp_id, rsp_err -> 0
  - ar_a, ar_b -> 0
  - counter -> 0
  - last_grant -> 1, so requester 0 wins the first contention.
REQ-029 Reset in ISSUE or RESP abandons the transaction: no response is produced and the operation is not replayed.
REQ-030 rst takes priority over every handshake in the same cycle.

Verification
REQ-031 The bench SHALL cover the following directed scenarios, with SETTLE=1 and a behavioural sumu3 model connected to the ar_* ports:
  - Single op: req0 a=3, b=1, op=00; rsp_ready=1 -> rsp_data=4, rsp_id=0, rsp_err=0; rsp_valid high exactly 2 cycles after the handshake.
  - Contention: req0 and req1 both valid from reset; req0 a=3, b=1, op=01; req1 a=3, b=1, op=10 -> first response rsp_data=3, rsp_id=0; second response rsp_data=2, rsp_id=1; req0 then wins the third contention.
  - Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant; req0_ready and req1_ready stay 0; busy stays 1; the response completes 1 cycle after rsp_ready rises.
  - Illegal op: req1 op=11 -> rsp_data=0, rsp_err=1, rsp_id=1; the following legal op returns rsp_err=0.
  - Reset mid-operation: rst pulsed in ISSUE -> no rsp_valid; all outputs at their reset values; a new request completes normally.
  - Operand stability: req0 changes a and b after the handshake -> ar_a/ar_b keep the latched values until the response completes.

Source files
------------

// File: rtl/sumu3_arb.sv
// Two-requester round-robin front end for a shared combinational sumu3 unit.
// One operation in flight; operands are held on ar_a/ar_b until the response is taken.
module sumu3_arb #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    input  logic [1:0] req0_op,
    input  logic [1:0] req1_op,
    output logic [1:0] ar_a,
    output logic [1:0] ar_b,
    input  logic [2:0] ar_sum,
    input  logic [2:0] ar_mult,
    input  logic [2:0] ar_abb,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_data,
    output logic       rsp_id,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    localparam logic [1:0] CntInit = 2'(SETTLE - 1);

    state_e     r_state, w_state_d;
    logic [1:0] r_cnt;
    logic [1:0] r_op;
    logic [1:0] r_ar_a, r_ar_b;
    logic       r_last;
    logic       r_rsp_valid, r_rsp_id, r_rsp_err, r_busy;
    logic [2:0] r_rsp_data;

    logic       w_gnt_valid, w_gnt_id, w_idle;
    logic [1:0] w_sel_a, w_sel_b, w_sel_op;

    // Both valid: the requester that did not win last time gets the grant.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = ~r_last;
        end else if (req0_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = 1'b0;
        end else if (req1_valid) begin
            w_gnt_valid = 1'b1;
            w_gnt_id    = 1'b1;
        end
    end

    always_comb begin
        w_sel_a  = w_gnt_id ? req1_a  : req0_a;
        w_sel_b  = w_gnt_id ? req1_b  : req0_b;
        w_sel_op = w_gnt_id ? req1_op : req0_op;
    end

    assign w_idle     = (r_state == StIdle) && !rst;
    assign req0_ready = w_idle && w_gnt_valid && !w_gnt_id;
    assign req1_ready = w_idle && w_gnt_valid && w_gnt_id;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_gnt_valid) w_state_d = StIssue;
            StIssue: if (r_cnt == 2'd0) w_state_d = StResp;
            StResp:  if (rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 2'd0;
            r_op        <= 2'd0;
            r_ar_a      <= 2'd0;
            r_ar_b      <= 2'd0;
            r_last      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 3'd0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_d != StIdle);
            unique case (r_state)
                StIdle: begin
                    if (w_gnt_valid) begin
                        r_ar_a   <= w_sel_a;
                        r_ar_b   <= w_sel_b;
                        r_op     <= w_sel_op;
                        r_rsp_id <= w_gnt_id;
                        r_last   <= w_gnt_id;
                        r_cnt    <= CntInit;
                    end
                end
                StIssue: begin
                    if (r_cnt == 2'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (r_op == 2'b11);
                        unique case (r_op)
                            2'b00:   r_rsp_data <= ar_sum;
                            2'b01:   r_rsp_data <= ar_mult;
                            2'b10:   r_rsp_data <= ar_abb;
                            default: r_rsp_data <= 3'd0;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ar_a      = r_ar_a;
    assign ar_b      = r_ar_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule
